pipe_reg_chain: RTL and testbench

PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

---
 rtl/pipe_reg_chain_pkg.sv | 13 +
 rtl/pipe_reg_chain_stage.sv | 43 ++++
 rtl/pipe_reg_chain.sv | 98 +++++++++
 tb/tb_pipe_reg_chain.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_chain_pkg.sv
// Shared constants and helpers for the pipe_reg_chain register slice.
package pipe_pkg;

  localparam int MAX_DEPTH = 8;

  // Occupancy counter width; never narrower than one bit so DEPTH=0 still has a port.
  function automatic int occ_width(input int depth);
    int w;
    w = $clog2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// One register stage of the chain: data word plus valid bit with load, flush and reset.
module pipe_stage #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         flush_i,
  input  logic         src_vld_i,
  input  logic [W-1:0] src_data_i,
  output logic         vld_o,
  output logic [W-1:0] data_o
);

  logic         vld_q, vld_d;
  logic [W-1:0] data_q, data_d;

  // Data is only captured from a valid source so bubbles leave the old word in place.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (flush_i) begin
      vld_d = 1'b0;
    end else if (load_i) begin
      vld_d = src_vld_i;
      if (src_vld_i) data_d = src_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// Valid/ready register chain of DEPTH stages with collapsing bubbles, clock enable and flush.
// Optional occupancy counter port occ is built only when PIPE_REG_CHAIN_OCC_EN is defined.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int W     = 18,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         c_en,
  input  logic         flush,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
`ifdef PIPE_REG_CHAIN_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occ
`endif
);

  localparam int D  = (DEPTH > MAX_DEPTH) ? MAX_DEPTH : DEPTH;
  localparam int OW = occ_width(DEPTH);

  if (D == 0) begin : gen_pass
    logic unused_ok;
    assign unused_ok = &{1'b0, flush, rst_n, clk};
    assign out_data  = in_data;
    assign out_valid = in_valid & c_en;
    assign in_ready  = out_ready & c_en;
`ifdef PIPE_REG_CHAIN_OCC_EN
    assign occ = '0;
`endif
  end else begin : gen_chain
    logic [D-1:0] vld_q;
    logic [W-1:0] data_q [D];
    logic [D-1:0] rdy;
    logic         advance;

    assign advance = c_en & ~flush;

    for (genvar i = 0; i < D; i++) begin : gen_stage
      logic         src_vld;
      logic [W-1:0] src_data;
      if (i == 0) begin : gen_head
        assign src_vld  = in_valid;
        assign src_data = in_data;
      end else begin : gen_link
        assign src_vld  = vld_q[i-1];
        assign src_data = data_q[i-1];
      end

      // A stage can take a new entry if any stage from here to the output end is empty.
      assign rdy[i] = out_ready | ~(&vld_q[D-1:i]);

      pipe_stage #(.W(W)) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (advance & rdy[i]),
        .flush_i    (flush),
        .src_vld_i  (src_vld),
        .src_data_i (src_data),
        .vld_o      (vld_q[i]),
        .data_o     (data_q[i])
      );
    end

    assign in_ready  = rdy[0] & advance;
    assign out_valid = vld_q[D-1] & advance;
    assign out_data  = data_q[D-1];

`ifdef PIPE_REG_CHAIN_OCC_EN
    logic [OW-1:0] occ_q, occ_d;
    logic          xfer_in, xfer_out;

    assign xfer_in  = in_valid & in_ready;
    assign xfer_out = out_valid & out_ready;

    always_comb begin
      occ_d = occ_q;
      if (flush)                    occ_d = '0;
      else if (xfer_in && !xfer_out) occ_d = occ_q + OW'(1);
      else if (!xfer_in && xfer_out) occ_d = occ_q - OW'(1);
    end

    always_ff @(posedge clk) begin
      if (!rst_n) occ_q <= '0;
      else        occ_q <= occ_d;
    end

    assign occ = occ_q;
`endif
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: four instances (DEPTH 3, 2, 0, 8) share one stimulus stream.
// An entry/position model of the chain is checked every cycle, plus literal scenario checks.
module tb_pipe_reg_chain;

  localparam int W = 18;
  localparam int DEP [4] = '{3, 2, 0, 8};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, c_en, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic [3:0]   inRdy, outVld;
  logic [W-1:0] outData [4];

  int  compared   = 0;
  int  mismatched = 0;
  bit  started    = 1'b0;

  int           mcnt [4];
  int           mpos [4][8];
  logic [W-1:0] mdat [4][8];

`ifdef PIPE_REG_CHAIN_OCC_EN
  logic [1:0] occ3, occ2;
  logic [0:0] occ0;
  logic [3:0] occ8;
  int         occV [4];
  always_comb begin
    occV[0] = int'(occ3);
    occV[1] = int'(occ2);
    occV[2] = int'(occ0);
    occV[3] = int'(occ8);
  end
`endif

  pipe_reg_chain #(.W(W), .DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .c_en(c_en), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(inRdy[0]),
    .out_data(outData[0]), .out_valid(outVld[0]), .out_ready(out_ready)
`ifdef PIPE_REG_CHAIN_OCC_EN
    , .occ(occ3)
`endif
  );

  pipe_reg_chain #(.W(W), .DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .c_en(c_en), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(inRdy[1]),
    .out_data(outData[1]), .out_valid(outVld[1]), .out_ready(out_ready)
`ifdef PIPE_REG_CHAIN_OCC_EN
    , .occ(occ2)
`endif
  );

  pipe_reg_chain #(.W(W), .DEPTH(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .c_en(c_en), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(inRdy[2]),
    .out_data(outData[2]), .out_valid(outVld[2]), .out_ready(out_ready)
`ifdef PIPE_REG_CHAIN_OCC_EN
    , .occ(occ0)
`endif
  );

  pipe_reg_chain #(.W(W), .DEPTH(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .c_en(c_en), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(inRdy[3]),
    .out_data(outData[3]), .out_valid(outVld[3]), .out_ready(out_ready)
`ifdef PIPE_REG_CHAIN_OCC_EN
    , .occ(occ8)
`endif
  );

  function automatic logic expInReady(input int k);
    if (DEP[k] == 0) return out_ready & c_en;
    return ((mcnt[k] < DEP[k]) || out_ready) && c_en && !flush;
  endfunction

  function automatic logic expOutValid(input int k);
    if (DEP[k] == 0) return in_valid & c_en;
    return (mcnt[k] > 0) && (mpos[k][0] == DEP[k] - 1) && c_en && !flush;
  endfunction

  function automatic logic [W-1:0] expOutData(input int k);
    if (DEP[k] == 0) return in_data;
    return mdat[k][0];
  endfunction

  task automatic checkOutput(input string name, input int k, input logic [63:0] act,
                             input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s (depth %0d) at %0t: got %0h, expected %0h",
               name, DEP[k], $time, act, exp);
    end
  endtask

  // Entries are kept oldest-first with their stage index; each one moves forward
  // unless the entry ahead of it is stuck directly in front.
  task automatic advanceModel(input int k);
    int           d, n, keep, aheadNew, p, np;
    int           npos [8];
    logic [W-1:0] ndat [8];
    logic         acc;
    d        = DEP[k];
    n        = mcnt[k];
    acc      = in_valid && ((n < d) || out_ready);
    keep     = 0;
    aheadNew = d;
    for (int e = 0; e < n; e++) begin
      p = mpos[k][e];
      if (e == 0 && p == d - 1 && out_ready) begin
        aheadNew = d;
      end else begin
        np = (p + 1 < aheadNew) ? p + 1 : p;
        npos[keep] = np;
        ndat[keep] = mdat[k][e];
        keep++;
        aheadNew = np;
      end
    end
    if (acc) begin
      npos[keep] = 0;
      ndat[keep] = in_data;
      keep++;
    end
    for (int e = 0; e < keep; e++) begin
      mpos[k][e] = npos[e];
      mdat[k][e] = ndat[e];
    end
    mcnt[k] = keep;
  endtask

  always @(posedge clk) begin : model
    if (!rst_n) begin
      started = 1'b1;
      for (int k = 0; k < 4; k++) mcnt[k] = 0;
    end else if (flush) begin
      for (int k = 0; k < 4; k++) mcnt[k] = 0;
    end else if (c_en) begin
      for (int k = 0; k < 4; k++) if (DEP[k] > 0) advanceModel(k);
    end
  end

  always @(negedge clk) begin : compare
    logic ev;
    if (started) begin
      for (int k = 0; k < 4; k++) begin
        checkOutput("in_ready", k, 64'(inRdy[k]), 64'(expInReady(k)));
        ev = expOutValid(k);
        checkOutput("out_valid", k, 64'(outVld[k]), 64'(ev));
        if (ev) checkOutput("out_data", k, 64'(outData[k]), 64'(expOutData(k)));
`ifdef PIPE_REG_CHAIN_OCC_EN
        checkOutput("occ", k, 64'(occV[k]), 64'(mcnt[k]));
`endif
      end
    end
  end

  task automatic applyStimulus(input bit rst, input bit ce, input bit fl, input bit iv,
                               input logic [W-1:0] d, input bit ordy);
    @(posedge clk);
    #1;
    rst_n     = rst;
    c_en      = ce;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 1, 0, 0, '0, 1);
  endtask

  initial begin
    rst_n = 1'b0; c_en = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    applyStimulus(0, 1, 0, 0, '0, 1);
    applyStimulus(0, 1, 0, 0, '0, 1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("rst_out_valid", k, 64'(outVld[k]), 64'd0);
      checkOutput("rst_out_data", k, 64'(outData[k]), 64'd0);
    end

    // Back-to-back stream through DEPTH=3
    applyStimulus(1, 1, 0, 1, 18'h00001, 1);
    checkOutput("lat_idle", 0, 64'(outVld[0]), 64'd0);
    applyStimulus(1, 1, 0, 1, 18'h00002, 1);
    applyStimulus(1, 1, 0, 1, 18'h00003, 1);
    checkOutput("lat_early", 0, 64'(outVld[0]), 64'd0);
    applyStimulus(1, 1, 0, 0, '0, 1);
    checkOutput("lat_valid", 0, 64'(outVld[0]), 64'd1);
    checkOutput("lat_first", 0, 64'(outData[0]), 64'h00001);
    applyStimulus(1, 1, 0, 0, '0, 1);
    checkOutput("lat_second", 0, 64'(outData[0]), 64'h00002);
    applyStimulus(1, 1, 0, 0, '0, 1);
    checkOutput("lat_third", 0, 64'(outData[0]), 64'h00003);
    applyStimulus(1, 1, 0, 0, '0, 1);
    checkOutput("lat_done", 0, 64'(outVld[0]), 64'd0);
    drain(10);

    // Full DEPTH=3 chain stalls, then drains and refills in the same cycle
    applyStimulus(1, 1, 0, 1, 18'h0000A, 0);
    applyStimulus(1, 1, 0, 1, 18'h0000B, 0);
    applyStimulus(1, 1, 0, 1, 18'h0000C, 0);
    applyStimulus(1, 1, 0, 1, 18'h0000D, 0);
    checkOutput("full_in_ready", 0, 64'(inRdy[0]), 64'd0);
    checkOutput("full_out_valid", 0, 64'(outVld[0]), 64'd1);
    checkOutput("full_hold_a", 0, 64'(outData[0]), 64'h0000A);
    applyStimulus(1, 1, 0, 1, 18'h0000D, 0);
    checkOutput("full_still_a", 0, 64'(outData[0]), 64'h0000A);
    applyStimulus(1, 1, 0, 1, 18'h0000D, 1);
    checkOutput("full_pass_ready", 0, 64'(inRdy[0]), 64'd1);
    applyStimulus(1, 1, 0, 0, '0, 1);
    checkOutput("full_next_b", 0, 64'(outData[0]), 64'h0000B);
    applyStimulus(1, 1, 0, 0, '0, 1);
    applyStimulus(1, 1, 0, 0, '0, 1);
    checkOutput("full_last_d", 0, 64'(outData[0]), 64'h0000D);
    drain(10);

    // Lone entry collapses to the output end while the consumer stalls
    applyStimulus(1, 1, 0, 1, 18'h0002A, 0);
    applyStimulus(1, 1, 0, 0, '0, 0);
    checkOutput("bubble_ready_s0", 0, 64'(inRdy[0]), 64'd1);
    applyStimulus(1, 1, 0, 0, '0, 0);
    checkOutput("bubble_idle_s1", 0, 64'(outVld[0]), 64'd0);
    applyStimulus(1, 1, 0, 0, '0, 0);
    checkOutput("bubble_at_end", 0, 64'(outVld[0]), 64'd1);
    checkOutput("bubble_data", 0, 64'(outData[0]), 64'h0002A);
    checkOutput("bubble_ready_s2", 0, 64'(inRdy[0]), 64'd1);
    drain(10);

    // Flush of a DEPTH=2 chain holding two entries
    applyStimulus(1, 1, 0, 1, 18'h00011, 0);
    applyStimulus(1, 1, 0, 1, 18'h00022, 0);
    applyStimulus(1, 1, 1, 0, '0, 0);
    checkOutput("flush_masks_valid", 1, 64'(outVld[1]), 64'd0);
    checkOutput("flush_masks_ready", 1, 64'(inRdy[1]), 64'd0);
    applyStimulus(1, 1, 0, 1, 18'h3FFFF, 1);
    checkOutput("flush_empty", 1, 64'(outVld[1]), 64'd0);
`ifdef PIPE_REG_CHAIN_OCC_EN
    checkOutput("flush_occ", 1, 64'(occ2), 64'd0);
`endif
    applyStimulus(1, 1, 0, 0, '0, 1);
    checkOutput("flush_refill_early", 1, 64'(outVld[1]), 64'd0);
    applyStimulus(1, 1, 0, 0, '0, 1);
    checkOutput("flush_refill_valid", 1, 64'(outVld[1]), 64'd1);
    checkOutput("flush_refill_data", 1, 64'(outData[1]), 64'h3FFFF);
    drain(10);

    // Clock enable low for four cycles freezes a DEPTH=2 chain
    applyStimulus(1, 1, 0, 1, 18'h00100, 1);
    applyStimulus(1, 1, 0, 1, 18'h00101, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 1, 18'h00102, 1);
      checkOutput("cen_in_ready", 1, 64'(inRdy[1]), 64'd0);
      checkOutput("cen_out_valid", 1, 64'(outVld[1]), 64'd0);
`ifdef PIPE_REG_CHAIN_OCC_EN
      checkOutput("cen_occ", 1, 64'(occ2), 64'd2);
`endif
    end
    applyStimulus(1, 1, 0, 0, '0, 1);
    checkOutput("cen_resume_valid", 1, 64'(outVld[1]), 64'd1);
    checkOutput("cen_resume_first", 1, 64'(outData[1]), 64'h00100);
    applyStimulus(1, 1, 0, 0, '0, 1);
    checkOutput("cen_resume_second", 1, 64'(outData[1]), 64'h00101);
    applyStimulus(1, 1, 0, 0, '0, 1);
    checkOutput("cen_resume_done", 1, 64'(outVld[1]), 64'd0);
    drain(10);

    // Mid-stream reset with pass-through and deep chains
    applyStimulus(1, 1, 0, 1, 18'h00555, 1);
    checkOutput("pass_echo_data", 2, 64'(outData[2]), 64'h00555);
    checkOutput("pass_echo_valid", 2, 64'(outVld[2]), 64'd1);
    applyStimulus(1, 1, 0, 1, 18'h00556, 1);
    applyStimulus(1, 1, 0, 1, 18'h00557, 1);
    applyStimulus(0, 1, 0, 1, 18'h00558, 1);
    applyStimulus(1, 1, 0, 0, '0, 1);
    checkOutput("mrst_valid8", 3, 64'(outVld[3]), 64'd0);
    checkOutput("mrst_data8", 3, 64'(outData[3]), 64'd0);
    checkOutput("mrst_valid0", 2, 64'(outVld[2]), 64'd0);
    checkOutput("mrst_data0", 2, 64'(outData[2]), 64'd0);
    checkOutput("mrst_ready8", 3, 64'(inRdy[3]), 64'd1);
`ifdef PIPE_REG_CHAIN_OCC_EN
    checkOutput("mrst_occ8", 3, 64'(occ8), 64'd0);
`endif
    drain(12);

    // Mixed traffic with stalls, enable gaps and occasional flushes
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1, ($urandom_range(0, 7) != 0), ($urandom_range(0, 23) == 0),
                    ($urandom_range(0, 3) != 0), W'($urandom),
                    ($urandom_range(0, 3) != 0));
    end
    drain(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
